// File: rtl/fir_sample_serializer.sv
// Sample FIFO feeding an LSB-first serializer for the FIR filter's serial input.
// Each word is framed by o_dout_valid and followed by a fixed idle gap.
module fir_sample_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [DATA_WIDTH-1:0]         i_word,
  input  logic                          i_word_valid,
  output logic                          o_word_ready,
  output logic                          o_dout,
  output logic                          o_dout_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy,
  output logic                          o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD_C = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  overflow_q, overflow_d;

  logic full_s, push_s, pop_s, bit_xfer_s, last_bit_s, gap_done_s;

  // Handshake qualifiers; full is taken from the registered count so a pop cannot free a slot early
  assign full_s     = (count_q == FULL_C);
  assign push_s     = i_word_valid && !full_s;
  assign pop_s      = (state_q == IDLE) && i_en && (count_q != {CNT_W{1'b0}});
  assign bit_xfer_s = (state_q == SHIFT) && i_ready;
  assign last_bit_s = (bit_cnt_q == LAST_BIT_C);
  assign gap_done_s = (gap_cnt_q == {GAP_W{1'b0}});

  assign o_word_ready = !full_s;
  assign o_fifo_count = count_q;
  assign o_overflow   = overflow_q;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_s) state_d = SHIFT; else state_d = IDLE;
      SHIFT:   if (bit_xfer_s && last_bit_s) state_d = GAP; else state_d = SHIFT;
      GAP:     if (gap_done_s) state_d = IDLE; else state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the serial line is forced low outside a word
  always_comb begin
    o_dout_valid = 1'b0;
    o_dout       = 1'b0;
    o_busy       = 1'b1;
    case (state_q)
      IDLE:    o_busy = 1'b0;
      SHIFT: begin
        o_dout_valid = 1'b1;
        o_dout       = shift_q[0];
      end
      GAP:     o_busy = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  // FIFO pointer, count and sticky overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) wr_ptr_d = wr_ptr_q + 1'b1; else wr_ptr_d = wr_ptr_q;
    if (pop_s)  rd_ptr_d = rd_ptr_q + 1'b1; else rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (i_word_valid && full_s) overflow_d = 1'b1; else overflow_d = overflow_q;
  end

  // Shift register, bit counter and gap counter next-state
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = {BIT_W{1'b0}};
        end else begin
          shift_d   = shift_q;
        end
      end
      SHIFT: begin
        if (bit_xfer_s) begin
          shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit_s) gap_cnt_d = GAP_LOAD_C; else gap_cnt_d = gap_cnt_q;
        end else begin
          shift_d   = shift_q;
        end
      end
      GAP: begin
        if (!gap_done_s) gap_cnt_d = gap_cnt_q - 1'b1; else gap_cnt_d = gap_cnt_q;
      end
      default: begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
      end
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
      shift_q    <= {DATA_WIDTH{1'b0}};
      bit_cnt_q  <= {BIT_W{1'b0}};
      gap_cnt_q  <= {GAP_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge i_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= i_word;
  end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Directed bench for fir_sample_serializer: a negedge monitor reassembles serial
// words and checks them against a queue of words pushed by the stimulus.
module tb_fir_sample_serializer;

  localparam int DW  = 24;
  localparam int GAP = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic [DW-1:0] i_word;
  logic          i_word_valid;
  logic          o_word_ready;
  logic          o_dout;
  logic          o_dout_valid;
  logic          i_ready;
  logic [2:0]    o_fifo_count;
  logic          o_busy;
  logic          o_overflow;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];

  // monitor state
  logic [DW-1:0] acc;
  int  nbits      = 0;
  int  run_len    = 0;
  int  low_len    = 0;
  int  win_words  = 0;
  bit  prev_v     = 1'b0;
  bit  have_prev  = 1'b0;
  bit  cont_ready = 1'b1;

  fir_sample_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_word       (i_word),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_ready      (i_ready),
    .o_fifo_count (o_fifo_count),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    i_word       = w;
    i_word_valid = 1'b1;
    exp_q.push_back(w);
    step();
    i_word_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while ((exp_q.size() != 0 || o_busy) && c < limit) begin
      step();
      c++;
    end
    check("drain_in_time", 32'(c < limit), 32'd1);
  endtask

  // Serial monitor: inputs change at posedge+1, so negedge shows what the next edge will transfer
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      nbits = 0; run_len = 0; low_len = 0; win_words = 0;
      prev_v = 1'b0; have_prev = 1'b0;
    end else if (o_dout_valid) begin
      if (!prev_v) begin
        if (have_prev) check("gap_len_min", 32'(low_len >= GAP + 1), 32'd1);
        run_len = 0;
        win_words = 0;
      end
      run_len++;
      if (i_ready) begin
        acc[nbits] = o_dout;
        nbits++;
        if (nbits == DW) begin
          nbits = 0;
          win_words++;
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("word", 32'(acc), 32'(exp_q.pop_front()));
        end
      end
      prev_v = 1'b1;
    end else begin
      if (prev_v) begin
        check("words_per_window", 32'(win_words), 32'd1);
        if (cont_ready) check("valid_len", 32'(run_len), 32'(DW));
        have_prev = 1'b1;
        low_len = 0;
      end
      low_len++;
      check("dout_low_when_invalid", 32'(o_dout), 32'd0);
      prev_v = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    i_rst_n = 1'b0; i_en = 1'b1; i_word = '0; i_word_valid = 1'b0; i_ready = 1'b1;

    // reset / idle
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("rst_valid",    32'(o_dout_valid), 32'd0);
    check("rst_ready",    32'(o_word_ready), 32'd1);
    check("rst_count",    32'(o_fifo_count), 32'd0);
    check("rst_overflow", 32'(o_overflow),   32'd0);
    check("rst_busy",     32'(o_busy),       32'd0);
    check("rst_dout",     32'(o_dout),       32'd0);

    // single word, sink always ready
    cont_ready = 1'b1;
    push_word(24'hA5C3F1);
    @(negedge i_clk);
    check("lat_valid_after_push", 32'(o_dout_valid), 32'd0);
    check("lat_count_after_push", 32'(o_fifo_count), 32'd1);
    @(negedge i_clk);
    check("lat_valid_after_load", 32'(o_dout_valid), 32'd1);
    check("lat_count_after_load", 32'(o_fifo_count), 32'd0);
    drain(100);
    check("single_count_end", 32'(o_fifo_count), 32'd0);

    // backpressure with ready pattern 1,0,0
    cont_ready = 1'b0;
    push_word(24'h800001);
    begin
      int c = 0;
      while ((exp_q.size() != 0 || o_busy) && c < 300) begin
        i_ready = (c % 3 == 0);
        step();
        c++;
      end
      check("bp_drain_in_time", 32'(c < 300), 32'd1);
    end
    i_ready = 1'b1;
    repeat (4) step();
    cont_ready = 1'b1;

    // fifo fill and overflow with i_en low
    i_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      i_word = DW'(i);
      i_word_valid = 1'b1;
      if (i <= 4) exp_q.push_back(DW'(i));
      step();
    end
    i_word_valid = 1'b0;
    @(negedge i_clk);
    check("fill_count",    32'(o_fifo_count), 32'd4);
    check("fill_ready",    32'(o_word_ready), 32'd0);
    check("fill_overflow", 32'(o_overflow),   32'd1);
    check("fill_busy",     32'(o_busy),       32'd0);
    i_en = 1'b1;
    drain(400);
    check("overflow_sticky", 32'(o_overflow), 32'd1);

    // reset mid-word
    push_word(24'hFFFFFF);
    begin
      int c = 0;
      while (nbits < 11 && c < 60) begin
        @(negedge i_clk);
        #2;
        c++;
      end
      check("midword_reached", 32'(nbits >= 11), 32'd1);
    end
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid_async", 32'(o_dout_valid), 32'd0);
    check("midrst_busy",        32'(o_busy),       32'd0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("midrst_count",    32'(o_fifo_count), 32'd0);
    check("midrst_overflow", 32'(o_overflow),   32'd0);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_dout_valid) vcount++;
    end
    check("midrst_no_residual", 32'(vcount), 32'd0);

    // simultaneous push and pop in IDLE
    i_en = 1'b0;
    push_word(24'h123456);
    push_word(24'h654321);
    push_word(24'hABCDEF);
    @(negedge i_clk);
    check("sim_pre_count", 32'(o_fifo_count), 32'd3);
    @(posedge i_clk);
    #1;
    i_en = 1'b1;
    push_word(24'h0F0F0F);
    @(negedge i_clk);
    check("sim_count_hold", 32'(o_fifo_count), 32'd3);
    check("sim_busy",       32'(o_busy),       32'd1);
    drain(500);
    check("sb_empty_end", 32'(exp_q.size()), 32'd0);
    check("end_count",    32'(o_fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sample_serializer.md
Name: fir_sample_serializer

Overview:
- Upstream stage of the FIR filter's serial input port.
- Buffers parallel signed samples, e.g. from a sine ROM or audio front end, in a small FIFO.
- Shifts each sample out LSB-first, one bit per accepted cycle, honouring the filter's bit-level ready.
- Frames each word with a valid window and enforces a minimum idle gap between words so the filter can realign.

Parameters:
DATA_WIDTH, 24, sample width in bits; also bits per serial word.
FIFO_DEPTH, 4, sample FIFO entries; power of two, >= 2.
GAP_CYCLES, 2, minimum cycles o_dout_valid stays low between consecutive words; >= 1.

Ports:
i_clk  in  1  single clock; all state on rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_en  in  1  when low, no new word starts; a word in progress completes.
i_word  in  DATA_WIDTH  parallel sample to enqueue.
i_word_valid  in  1  enqueue request for i_word.
o_word_ready  out  1  FIFO not full; a push occurs on an edge with i_word_valid && o_word_ready.
o_dout  out  1  serial data bit, LSB first.
o_dout_valid  out  1  high for the whole duration of one serial word.
i_ready  in  1  downstream bit-ready; a bit transfers on an edge with o_dout_valid && i_ready.
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
o_busy  out  1  FSM not in IDLE.
o_overflow  out  1  sticky; set when i_word_valid is high while the FIFO is full.

Behaviour:
- Reset (async assert, sync-release use):
  - o_dout = 0, o_dout_valid = 0, o_busy = 0, o_overflow = 0, o_fifo_count = 0, o_word_ready = 1.
  - FSM goes to IDLE; FIFO pointers and bit counter clear.
  - Reset mid-word abandons the word, with no further bits.
- FIFO:
  - Circular buffer with write/read pointers and a count.
  - o_word_ready = (count != FIFO_DEPTH), combinational from registered count only.
  - No push when full, even if a pop occurs the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - A push attempted while full drops the word and sets o_overflow, which stays set until reset.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if i_en && count != 0, load the FIFO head into a shift register, pop, clear the bit counter, and go to SHIFT.
  - Latency: a word pushed into an empty FIFO at edge N is loaded at edge N+1; o_dout_valid is high after edge N+1.
  - SHIFT:
    - o_dout_valid = 1 and o_dout = shift_reg[0].
    - On each edge with i_ready = 1, shift right and increment the bit counter.
    - When i_ready = 0, hold o_dout and the counter, with o_dout_valid staying high.
    - On the transfer of bit DATA_WIDTH-1, go to GAP and load the gap counter with GAP_CYCLES-1.
  - GAP:
    - o_dout_valid = 0 and o_dout = 0.
    - Decrement the counter each cycle; at 0 go to IDLE.
    - i_ready is ignored.
  - Minimum spacing is exactly GAP_CYCLES low cycles plus 1 IDLE cycle between words with a continuously ready sink and a non-empty FIFO.
- i_en:
  - Sampled only in IDLE.
  - Dropping i_en during SHIFT or GAP has no effect until IDLE.
- Bit order:
  - Bit j of the sample appears on the j-th accepted transfer, j = 0..DATA_WIDTH-1.
  - Two's-complement bits pass unmodified; no sign handling.
- o_fifo_count reflects the registered count.
- o_busy = (state != IDLE).

Test Plan:
- Reset/idle: hold i_rst_n = 0 for 3 cycles, release -> o_dout_valid = 0, o_word_ready = 1, o_fifo_count = 0, o_overflow = 0.
- Single word, i_ready = 1 constant: push 24'hA5C3F1 -> o_dout_valid rises 1 cycle after the push edge and stays high for exactly 24 cycles; captured bits LSB-first reassemble to 24'hA5C3F1; then valid stays low for 2 cycles.
- Backpressure: push 24'h800001 with i_ready toggling 1,0,0,1,... -> valid never drops mid-word; exactly 24 transfers occur; reassembled word = 24'h800001 (sign bit last).
- FIFO fill/overflow: with i_en = 0, push 5 words 1..5 back-to-back -> o_fifo_count = 4, o_word_ready = 0, word 5 dropped, o_overflow = 1. Then i_en = 1 -> words 1,2,3,4 emerge in order, each separated by >= 2 invalid cycles, and o_overflow stays 1.
- Reset mid-word: assert i_rst_n = 0 after 10 bits of 24'hFFFFFF -> o_dout_valid = 0 immediately (async); after release, count = 0 and no residual bits are emitted.
- Simultaneous push/pop: FIFO holds 3 words; push on the same edge the FSM pops in IDLE -> o_fifo_count stays 3 and order is preserved.
